// File: rtl/gray_frame_sequencer.sv
// Frame sequencer for the RGB-to-grayscale stage: raster-order frame-buffer reads,
// luma conversion and a 2-entry credited output FIFO with sof/eol/eof markers.
module gray_frame_sequencer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_inflight;
  logic [2:0]        r_fl_mark;
  logic [10:0]       r_mem [2];
  logic              r_wptr, r_rptr;
  logic [1:0]        r_count;

  logic        w_pop, w_push;
  logic [2:0]  w_credit;
  logic [15:0] w_y16;
  logic        w_sof, w_eol, w_eof;

  assign w_y16 = 16'd77  * {8'h00, rd_data[23:16]}
               + 16'd150 * {8'h00, rd_data[15:8]}
               + 16'd29  * {8'h00, rd_data[7:0]}
               + 16'd128;

  assign w_sof = (r_x == '0) && (r_y == '0);
  assign w_eol = (r_x == X_LAST);
  assign w_eof = w_eol && (r_y == Y_LAST);

  assign m_valid  = (r_count != 2'd0);
  assign w_pop    = m_valid & m_ready;
  assign w_push   = r_inflight;
  // Occupancy after this cycle's pop, counting the read already in the RAM pipe.
  assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign rd_addr = r_addr;
  assign m_data  = r_mem[r_rptr][10:3];
  assign m_sof   = r_mem[r_rptr][2];
  assign m_eol   = r_mem[r_rptr][1];
  assign m_eof   = r_mem[r_rptr][0];

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    rd_en  = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN: begin
        busy  = 1'b1;
        rd_en = (w_credit < 3'd2);
        if (rd_en && (r_addr == A_LAST)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if ((r_count == 2'd0) && !r_inflight) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_inflight <= 1'b0;
      r_fl_mark  <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= '0;
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= rd_en;
      if ((r_state == S_IDLE) && start) begin
        r_addr <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end else if (rd_en) begin
        r_addr    <= r_addr + 1'b1;
        r_fl_mark <= {w_sof, w_eol, w_eof};
        if (w_eol) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      if (w_push) begin
        r_mem[r_wptr] <= {w_y16[15:8], r_fl_mark};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// Scoreboard bench for gray_frame_sequencer on a 4x3 frame with a 1-cycle RAM model.
module tb_gray_frame_sequencer;
  localparam int W = 4, H = 3, AW = 4, N = W * H;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, rd_en, m_valid, m_ready;
  logic          m_sof, m_eol, m_eof;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data;
  logic [7:0]    m_data;

  logic [23:0] fb [16];
  logic [7:0]  exp_gray [N];
  logic [10:0] q [$];
  int checks = 0, errors = 0;
  int hs = 0, rd_cnt = 0, done_cnt = 0, outstanding = 0;
  logic [AW-1:0] exp_addr = '0;
  logic          prev_stall = 1'b0;
  logic [11:0]   prev_out = '0;

  gray_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= fb[rd_addr];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++)
      q.push_back({exp_gray[i], i == 0, (i % W) == W - 1, i == N - 1});
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk(nm, int'(seen), 1);
    chk({nm, "_q_empty"}, q.size(), 0);
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {busy, done, rd_en, rd_addr, m_valid, m_data, m_sof, m_eol, m_eof}, 0);
  endtask

  // Monitor: scoreboard pops, address sequence, credit bound, stall stability.
  always @(negedge clk) begin
    if (rst) begin
      exp_addr    = '0;
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) chk("hold", {m_valid, m_data, m_sof, m_eol, m_eof}, prev_out);
      if (m_valid && m_ready) begin
        hs++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_pixel actual 0x%0h required none", m_data);
        end else begin
          chk("pixel", {m_data, m_sof, m_eol, m_eof}, q.pop_front());
        end
      end
      outstanding += int'(rd_en) - int'(m_valid && m_ready);
      if (rd_en) begin
        rd_cnt++;
        chk("rd_addr", rd_addr, exp_addr);
        chk("credit", int'(outstanding <= 2), 1);
        exp_addr = (exp_addr == AW'(N - 1)) ? '0 : exp_addr + 1'b1;
      end
      if (done) done_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_valid, m_data, m_sof, m_eol, m_eof};
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, h0, d0;
    fb[0]  = 24'hFFFFFF; exp_gray[0]  = 8'd255;
    fb[1]  = 24'hFF0000; exp_gray[1]  = 8'd77;
    fb[2]  = 24'h00FF00; exp_gray[2]  = 8'd149;
    fb[3]  = 24'h0000FF; exp_gray[3]  = 8'd29;
    fb[4]  = 24'h808080; exp_gray[4]  = 8'd128;
    fb[5]  = 24'h000000; exp_gray[5]  = 8'd0;
    fb[6]  = 24'h123456; exp_gray[6]  = 8'd46;
    fb[7]  = 24'hABCDEF; exp_gray[7]  = 8'd199;
    fb[8]  = 24'h010203; exp_gray[8]  = 8'd2;
    fb[9]  = 24'h7F7F7F; exp_gray[9]  = 8'd127;
    fb[10] = 24'h00FFFF; exp_gray[10] = 8'd178;
    fb[11] = 24'hC0FFEE; exp_gray[11] = 8'd234;
    for (int i = N; i < 16; i++) fb[i] = 24'hDEAD00;

    rst = 1'b1; start = 1'b0; m_ready = 1'b1;
    repeat (3) cyc();
    chk_idle("reset_state");
    rst = 1'b0;
    cyc();

    // Frame 1: full-rate streaming and latency.
    push_frame();
    start = 1'b1;
    chk("idle_no_rd", rd_en, 0);
    cyc(); start = 1'b0;
    chk("first_rd_en", rd_en, 1);
    chk("busy_run", busy, 1);
    chk("mvalid_t1", m_valid, 0);
    cyc();
    chk("mvalid_t2", m_valid, 0);
    cyc();
    for (int i = 0; i < N; i++) begin
      chk("stream_f1", m_valid, 1);
      if (i < N - 1) cyc();
    end
    wait_done("done_f1");
    cyc();
    chk("busy_after_done", busy, 0);
    chk("done_one_pulse", done, 0);

    // Frame 2: random backpressure.
    push_frame();
    r0 = rd_cnt; h0 = hs; d0 = done_cnt;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      m_ready = ($urandom_range(0, 9) < 3);
      cyc();
      if (done_cnt > d0) break;
    end
    chk("bp_done", done_cnt - d0, 1);
    chk("bp_reads", rd_cnt - r0, N);
    chk("bp_handshakes", hs - h0, N);
    chk("bp_q_empty", q.size(), 0);

    // Frame 3: stall 20 cycles right after start.
    m_ready = 1'b0;
    cyc();
    push_frame();
    r0 = rd_cnt;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (19) cyc();
    chk("stall_reads", rd_cnt - r0, 2);
    chk("stall_valid", m_valid, 1);
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("stream_f3", m_valid, 1);
      if (i < N - 1) cyc();
    end
    wait_done("done_f3");
    cyc();

    // Frames 4a/4b: mid-frame start ignored, start held across done.
    push_frame();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    start = 1'b1;
    wait_done("done_f4a");
    cyc();
    push_frame();
    chk("idle_after_done", {busy, rd_en}, 0);
    cyc(); start = 1'b0;
    chk("restart_rd_en", rd_en, 1);
    chk("restart_addr", rd_addr, 0);
    wait_done("done_f4b");
    cyc();

    // Frame 5: reset at pixel 5, then a clean frame.
    push_frame();
    h0 = hs;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 100 && (hs - h0) < 5; i++) cyc();
    chk("reached_px5", hs - h0, 5);
    rst = 1'b1; m_ready = 1'b0;
    cyc();
    chk_idle("midframe_reset");
    rst = 1'b0;
    q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("no_valid_after_rst", {m_valid, busy}, 0);
    end
    push_frame();
    r0 = rd_cnt; h0 = hs;
    start = 1'b1; cyc(); start = 1'b0;
    wait_done("done_f6");
    chk("f6_reads", rd_cnt - r0, N);
    chk("f6_handshakes", hs - h0, N);
    cyc();
    chk("total_done", done_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_frame_sequencer.md
Name: gray_frame_sequencer

Overview:
- Frame-level controller for the RGB-to-8-bit-grayscale stage.
- On a start pulse it walks the RGB frame buffer in raster order and issues synchronous reads.
- It converts each returned pixel to luma and streams the results downstream over a valid/ready interface with frame and line markers.
- Sits between the RGB frame buffer and the salt-and-pepper median filter / edge-detection pipeline.

Parameters:
- IMG_W, 320, pixels per line (>=2).
- IMG_H, 240, lines per frame (>=1).
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to process one frame; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshake.
- rd_en  out  1  frame-buffer read strobe.
- rd_addr  out  ADDR_W  frame-buffer read address (0 .. IMG_W*IMG_H-1).
- rd_data  in  24  {R[23:16],G[15:8],B[7:0]}; valid exactly one cycle after rd_en.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accept.
- m_data  out  8  gray pixel.
- m_sof  out  1  qualifies the first pixel of the frame.
- m_eol  out  1  qualifies the last pixel of each line.
- m_eof  out  1  qualifies the last pixel of the frame.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_sof=m_eol=m_eof=0. State=IDLE, output FIFO empty, in-flight flag cleared.
- Reset mid-frame: returns to IDLE the next cycle. No partial pixels are emitted afterwards, and the read data returning after reset is discarded.
- Conversion (combinational on rd_data):
  - y16 = 77*R + 150*G + 29*B + 128, computed in 16 bits; cannot overflow.
  - m_data = y16[15:8].
- States:
  - IDLE: on start -> RUN; rd pixel counter=0, x=0, y=0.
  - RUN: issue reads as credit allows. After the read of pixel IMG_W*IMG_H-1 is issued -> DRAIN.
  - DRAIN: no reads. When the FIFO is empty and nothing is in flight -> DONE.
  - DONE: done=1 for one cycle, busy=0 from that cycle -> IDLE.
- start outside IDLE is ignored.
- Buffering:
  - 2-entry output FIFO holds {gray, sof, eol, eof}.
  - Returning read data is written into the FIFO the cycle it arrives.
  - m_valid = FIFO not empty; pop on m_valid & m_ready.
- Credit rule: rd_en = (state==RUN) & (count + inflight - pop < 2). This guarantees no FIFO overflow and sustains 1 pixel/clk while m_ready is held high.
- Latency: start -> first rd_en = 1 cycle; rd_en -> m_valid = 2 cycles (1 cycle RAM, 1 cycle FIFO register).
- Markers are computed from the read-side x/y counters and travel with the pixel:
  - sof when x=0,y=0.
  - eol when x=IMG_W-1.
  - eof when x=IMG_W-1,y=IMG_H-1.
- Counter advance on each rd_en:
  - x wraps at IMG_W-1 to 0 and increments y.
  - rd_addr increments by 1.
- Output hold: while m_valid=1 and m_ready=0, m_data and the markers hold stable.
- Totals: exactly IMG_W*IMG_H handshakes per frame, then done.
- Frame restart: a new start is accepted on the cycle after done (back-to-back frames).

Test Plan:
- IMG_W=4, IMG_H=3, m_ready=1, buffer filled with address-derived pixels, start pulse -> 12 consecutive handshakes with first m_valid 3 cycles after start. sof only on pixel 0, eol on pixels 3/7/11, eof on pixel 11; done pulses once after the last handshake, busy low afterwards.
- Conversion values:
  - FFFFFF -> 255.
  - FF0000 -> 77.
  - 00FF00 -> 149.
  - 0000FF -> 29.
  - 808080 -> 128.
  - 000000 -> 0.
- Backpressure: m_ready random 30% duty over a 4x3 frame -> no rd_en while count+inflight=2. Data and markers stable while stalled, order preserved, exactly 12 handshakes, no lost or duplicated pixels.
- m_ready=0 for 20 cycles right after start -> exactly 2 reads issued then rd_en stays 0. On release, the remaining 10 pixels flow at 1/clk.
- start asserted again mid-frame, and start held high across done -> the mid-frame pulse is ignored. A second frame begins on the cycle after done, with sof on its first pixel.
- rst asserted for 1 cycle at pixel 5 of a 4x3 frame -> next cycle all outputs at reset values, no m_valid until a new start. The following frame produces 12 clean pixels from address 0.
